// File: rtl/acc_requant.sv
// Requantizing accumulator: sums signed 16-bit products into an ACC_W-bit register,
// then rounds, shifts and saturates the dot product to OUT_W bits. Optional ReLU clamp: ACC_REQUANT_RELU_EN.
module acc_requant #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             in_first,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [4:0]       cfg_shift,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic                    accept;
  logic signed [ACC_W-1:0] beat_ext;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W:0]   rq_c;
  logic [OUT_W:0]          sat_c;

  // Round half up, then arithmetic shift; one guard bit keeps the rounding add from wrapping.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] sum,
                                                        input logic [4:0] sh);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    ext = {sum[ACC_W-1], sum};
    rnd = '0;
    if (sh != 5'd0) rnd = {{ACC_W{1'b0}}, 1'b1} << (sh - 5'd1);
    return (ext + rnd) >>> sh;
  endfunction

  // Returns {clipped, value} with value limited to the signed OUT_W range.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] v);
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    hi = '0;
    hi[OUT_W-2:0] = '1;
    lo = ~hi;
    if (v > hi) begin
      return {1'b1, hi[OUT_W-1:0]};
    end else if (v < lo) begin
`ifdef ACC_REQUANT_RELU_EN
      return {1'b0, {OUT_W{1'b0}}};
`else
      return {1'b1, lo[OUT_W-1:0]};
`endif
    end
`ifdef ACC_REQUANT_RELU_EN
    if (v < 0) return {1'b0, {OUT_W{1'b0}}};
`endif
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  assign beat_ext = {{(ACC_W-16){in_data[15]}}, in_data};
  assign sum_c    = in_first ? beat_ext : acc_q + beat_ext;
  assign rq_c     = round_shift(sum_c, cfg_shift);
  assign sat_c    = saturate(rq_c);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (accept) begin
      if (in_last) begin
        state_d    = OUT;
        acc_d      = '0;
        out_data_d = sat_c[OUT_W-1:0];
        out_sat_d  = sat_c[OUT_W];
      end else begin
        state_d = ACC;
        acc_d   = sum_c;
      end
    end else if (state_q == OUT && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_acc_requant.sv
// Directed bench for acc_requant: hand-computed dot products, stall, restart and reset.
module tb_acc_requant;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic [15:0] in_data;
  logic       in_first;
  logic       in_last;
  logic       in_ready;
  logic [4:0] cfg_shift;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sat;
  logic       out_ready;

  int n_cmp = 0;
  int n_err = 0;

  acc_requant #(.ACC_W(32), .OUT_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .in_ready(in_ready), .cfg_shift(cfg_shift),
    .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int exp_data, input logic exp_sat);
    logic [7:0] e8;
    e8 = 8'(exp_data);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".data"}, {24'b0, out_data}, {24'b0, e8});
    chk({tag, ".sat"}, {31'b0, out_sat}, {31'b0, exp_sat});
  endtask

  task automatic beat(input int d, input logic f, input logic l, input logic [4:0] sh);
    in_valid  = 1'b1;
    in_data   = 16'(d);
    in_first  = f;
    in_last   = l;
    cfg_shift = sh;
    tick();
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_data   = 16'hDEAD;
    cfg_shift = 5'd7;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    chk("drain.valid", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_first = 1'b0; in_last = 1'b0;
    cfg_shift = '0; out_ready = 1'b1;
    tick();
    chk("rst.valid", {31'b0, out_valid}, 32'd0);
    chk("rst.data", {24'b0, out_data}, 32'd0);
    chk("rst.sat", {31'b0, out_sat}, 32'd0);
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
    rstn = 1'b1;
    tick();
    chk("post_rst.in_ready", {31'b0, in_ready}, 32'd1);

    // 100 + 200 - 50 = 250; (250 + 2) >>> 2 = 63
    beat(100, 1'b1, 1'b0, 5'd0);
    beat(200, 1'b0, 1'b0, 5'd0);
    chk("dot3.early_valid", {31'b0, out_valid}, 32'd0);
    beat(-50, 1'b0, 1'b1, 5'd2);
    chk_res("dot3", 63, 1'b0);
    drain();

    beat(16'h7FFF, 1'b1, 1'b1, 5'd0);
    chk_res("pos_clip", 127, 1'b1);
    drain();
    beat(16'h8000, 1'b1, 1'b1, 5'd0);
`ifdef ACC_REQUANT_RELU_EN
    chk_res("neg_clip", 0, 1'b0);
`else
    chk_res("neg_clip", -128, 1'b1);
`endif
    drain();

    // Backpressure: result held for 5 cycles, then replaced by a simultaneous last beat
    out_ready = 1'b0;
    beat(50, 1'b1, 1'b1, 5'd0);
    chk_res("stall.first", 50, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'd99; in_first = 1'b1; in_last = 1'b1;
      #1;
      chk("stall.in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk_res("stall.hold", 50, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'd20; in_first = 1'b1; in_last = 1'b1; cfg_shift = 5'd0;
    #1;
    chk("stall.release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    chk_res("stall.second", 20, 1'b0);
    drain();

    // Restart mid-sum discards 10 + 10
    beat(10, 1'b1, 1'b0, 5'd0);
    beat(10, 1'b0, 1'b0, 5'd0);
    beat(5, 1'b1, 1'b0, 5'd0);
    beat(5, 1'b0, 1'b1, 5'd0);
    chk_res("restart", 10, 1'b0);
    drain();

    // Reset mid-accumulation clears the partial sum and emits nothing
    beat(7, 1'b1, 1'b0, 5'd0);
    beat(8, 1'b0, 1'b0, 5'd0);
    rstn = 1'b0;
    #1;
    chk("midrst.in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    rstn = 1'b1;
    chk("midrst.valid", {31'b0, out_valid}, 32'd0);
    tick();
    chk("midrst.valid2", {31'b0, out_valid}, 32'd0);
    beat(4, 1'b0, 1'b1, 5'd0);
    chk_res("midrst.acc_cleared", 4, 1'b0);
    drain();
    beat(3, 1'b1, 1'b1, 5'd0);
    chk_res("midrst.single", 3, 1'b0);
    drain();

    // -1.5 rounds half up to -1
    beat(-3, 1'b1, 1'b1, 5'd1);
`ifdef ACC_REQUANT_RELU_EN
    chk_res("round_neg", 0, 1'b0);
`else
    chk_res("round_neg", -1, 1'b0);
`endif
    drain();

    // Non-last beat accepted while result drains goes straight to accumulation
    out_ready = 1'b0;
    beat(40, 1'b1, 1'b1, 5'd0);
    chk_res("chain.first", 40, 1'b0);
    out_ready = 1'b1;
    beat(6, 1'b1, 1'b0, 5'd0);
    chk("chain.valid_drop", {31'b0, out_valid}, 32'd0);
    beat(7, 1'b0, 1'b1, 5'd1);
    chk_res("chain.second", 7, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
